losowanie_scheduler: RTL and testbench

- Multi-player lottery draw controller with drawing without replacement.
- A free-running counter is shared between PLAYERS requesters. Each requester may draw once.
- A round-robin arbiter picks one pending press at a time. A search FSM then skips already-drawn values, so every player gets a distinct number.
- Sits between the mouse/button inputs and the result display logic of the emulator.

---
 rtl/losowanie_scheduler.sv | 113 +++++++++++
 tb/tb_losowanie_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/losowanie_scheduler.sv
// Purpose : multi-player lottery draw; round-robin grant of pending presses, then a
//           search over a shared free-running counter that skips already-drawn values.
// Latency : grant in IDLE at cycle t -> result_valid at t+2+k (k = used values skipped).
// Backpressure: none; one draw per >=3 cycles, pending presses wait in round-robin order.
// Ports   : clock/reset_ (sync, active-high); press_ per-player level requests;
//           result_valid one-cycle pulse with result/result_player (held between pulses);
//           player_done_ per-player drawn flags, all_done_ = AND of them; busy = FSM not IDLE.
module losowanie_scheduler #(
    parameter int PLAYERS = 4,
    parameter int VALUE_W = 2,
    parameter int PID_W   = 2
) (
    input  logic               clock,
    input  logic               reset_,
    input  logic [PLAYERS-1:0] press_,
    output logic               result_valid,
    output logic [VALUE_W-1:0] result,
    output logic [PID_W-1:0]   result_player,
    output logic [PLAYERS-1:0] player_done_,
    output logic               all_done_,
    output logic               busy
);

    localparam int NVAL = 2 ** VALUE_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t             state;
    logic [VALUE_W-1:0] counter;
    logic [VALUE_W-1:0] candidate;
    logic [NVAL-1:0]    used;
    logic [PID_W-1:0]   rr_ptr;
    logic [PID_W-1:0]   grant_reg;

    logic [PLAYERS-1:0] pending;
    logic               grant_vld;
    logic [PID_W-1:0]   grant_idx;
    logic [PID_W:0]     scan_idx;

    // Players that already drew cannot compete again.
    assign pending = press_ & ~player_done_;

    // Round-robin pick: first pending bit at or above rr_ptr, wrapping modulo PLAYERS.
    // One extra bit on scan_idx keeps rr_ptr+i from overflowing before the wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int i = 0; i < PLAYERS; i++) begin
            scan_idx = {1'b0, rr_ptr} + (PID_W+1)'(i);
            if (scan_idx >= (PID_W+1)'(PLAYERS))
                scan_idx = scan_idx - (PID_W+1)'(PLAYERS);
            if (!grant_vld && pending[scan_idx[PID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx[PID_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset_) begin
            state         <= IDLE;
            counter       <= '0;
            candidate     <= '0;
            used          <= '0;
            rr_ptr        <= '0;
            grant_reg     <= '0;
            result        <= '0;
            result_player <= '0;
            result_valid  <= 1'b0;
            player_done_  <= '0;
        end else begin
            counter      <= counter + 1'b1;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        grant_reg <= grant_idx;
                        candidate <= counter;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    // A free value always exists since PLAYERS <= 2**VALUE_W,
                    // so this walk ends within NVAL cycles.
                    if (!used[candidate]) begin
                        used[candidate]         <= 1'b1;
                        result                  <= candidate;
                        result_player           <= grant_reg;
                        player_done_[grant_reg] <= 1'b1;
                        result_valid            <= 1'b1;
                        state                   <= REPORT;
                    end else begin
                        candidate <= candidate + 1'b1;
                    end
                end
                REPORT: begin
                    rr_ptr <= (grant_reg == PID_W'(PLAYERS - 1)) ? '0 : grant_reg + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign all_done_ = &player_done_;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_losowanie_scheduler.sv
// Purpose : directed self-checking bench for losowanie_scheduler (PLAYERS=4, VALUE_W=2).
// Latency : inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; fixed cycle-by-cycle stimulus.
module tb_losowanie_scheduler;

    logic       clock;
    logic       reset_;
    logic [3:0] press_;
    logic       result_valid;
    logic [1:0] result;
    logic [1:0] result_player;
    logic [3:0] player_done_;
    logic       all_done_;
    logic       busy;

    int checks = 0;
    int errors = 0;

    losowanie_scheduler #(
        .PLAYERS(4),
        .VALUE_W(2),
        .PID_W  (2)
    ) dut (
        .clock        (clock),
        .reset_       (reset_),
        .press_       (press_),
        .result_valid (result_valid),
        .result       (result),
        .result_player(result_player),
        .player_done_ (player_done_),
        .all_done_    (all_done_),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (result_valid)
            $display("wynik gracza %0d: %0d", result_player, int'(result) + 1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // On return we are in the first cycle after reset release (internal counter = 0).
    task automatic do_reset();
        reset_ = 1'b1;
        press_ = 4'b0000;
        step();
        step();
        reset_ = 1'b0;
    endtask

    // All-press expectations: pulse cycles and their (result, player).
    int         ap_cyc [4] = '{2, 5, 8, 11};
    logic [1:0] ap_res [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
    logic [1:0] ap_pid [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        reset_ = 1'b1;
        press_ = 4'b0000;

        // ---------------- reset state + basic draw ----------------
        do_reset();                                  // c0, counter 0
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_player", 32'(result_player), 32'd0);
        chk("rst_done", 32'(player_done_), 32'd0);
        chk("rst_all", 32'(all_done_), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();                                      // c1
        step();                                      // c2, counter 2
        press_ = 4'b0001;
        step();                                      // c3 SEARCH
        press_ = 4'b0000;
        chk("basic_busy_s", 32'(busy), 32'd1);
        chk("basic_valid_s", 32'(result_valid), 32'd0);
        step();                                      // c4 REPORT
        chk("basic_valid", 32'(result_valid), 32'd1);
        chk("basic_result", 32'(result), 32'd2);
        chk("basic_player", 32'(result_player), 32'd0);
        chk("basic_done", 32'(player_done_), 32'b0001);
        chk("basic_busy_r", 32'(busy), 32'd1);
        chk("basic_all", 32'(all_done_), 32'd0);
        step();                                      // c5 IDLE
        chk("basic_valid_end", 32'(result_valid), 32'd0);
        chk("basic_busy_end", 32'(busy), 32'd0);
        chk("basic_hold", 32'(result), 32'd2);

        // ---------------- duplicate skip ----------------
        step();                                      // c6, counter 2
        press_ = 4'b0010;
        step();                                      // c7 SEARCH cand 2 (used)
        press_ = 4'b0000;
        chk("dup_busy", 32'(busy), 32'd1);
        step();                                      // c8 SEARCH cand 3
        chk("dup_valid_early", 32'(result_valid), 32'd0);
        chk("dup_busy2", 32'(busy), 32'd1);
        step();                                      // c9 REPORT
        chk("dup_valid", 32'(result_valid), 32'd1);
        chk("dup_result", 32'(result), 32'd3);
        chk("dup_player", 32'(result_player), 32'd1);
        chk("dup_done", 32'(player_done_), 32'b0011);
        step();                                      // c10 IDLE

        // ---------------- repeat press by done player ----------------
        press_ = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rep_valid", 32'(result_valid), 32'd0);
            chk("rep_busy", 32'(busy), 32'd0);
        end
        chk("rep_result", 32'(result), 32'd3);
        chk("rep_player", 32'(result_player), 32'd1);
        chk("rep_done", 32'(player_done_), 32'b0011);

        // ---------------- reset mid-SEARCH ----------------
        press_ = 4'b0100;
        step();                                      // SEARCH for player 2
        press_ = 4'b0000;
        chk("mid_busy", 32'(busy), 32'd1);
        reset_ = 1'b1;
        step();                                      // first cycle after reset
        reset_ = 1'b0;
        chk("mid_valid", 32'(result_valid), 32'd0);
        chk("mid_done", 32'(player_done_), 32'd0);
        chk("mid_result", 32'(result), 32'd0);
        chk("mid_player", 32'(result_player), 32'd0);
        chk("mid_busy0", 32'(busy), 32'd0);
        step();                                      // c1
        chk("mid_valid2", 32'(result_valid), 32'd0);
        step();                                      // c2, counter 2
        press_ = 4'b0001;
        step();                                      // c3 SEARCH
        press_ = 4'b0000;
        step();                                      // c4 REPORT
        chk("mid_fresh_valid", 32'(result_valid), 32'd1);
        chk("mid_fresh_result", 32'(result), 32'd2);
        chk("mid_fresh_player", 32'(result_player), 32'd0);

        // ---------------- all players pressing ----------------
        do_reset();                                  // c0
        press_ = 4'b1111;
        for (int c = 1; c <= 16; c++) begin
            int k;
            step();
            k = -1;
            for (int j = 0; j < 4; j++)
                if (ap_cyc[j] == c) k = j;
            chk("all_valid", 32'(result_valid), (k >= 0) ? 32'd1 : 32'd0);
            if (k >= 0) begin
                chk("all_result", 32'(result), 32'(ap_res[k]));
                chk("all_player", 32'(result_player), 32'(ap_pid[k]));
                chk("all_alldone", 32'(all_done_), (k == 3) ? 32'd1 : 32'd0);
            end
        end
        chk("all_done_vec", 32'(player_done_), 32'b1111);
        chk("all_busy_end", 32'(busy), 32'd0);
        press_ = 4'b0000;

        // ---------------- round-robin pointer ----------------
        do_reset();                                  // c0
        press_ = 4'b0010;
        step();                                      // c1 SEARCH
        press_ = 4'b0000;
        step();                                      // c2 REPORT
        chk("rr_first_valid", 32'(result_valid), 32'd1);
        chk("rr_first_player", 32'(result_player), 32'd1);
        chk("rr_first_result", 32'(result), 32'd0);
        press_ = 4'b1001;
        step();                                      // c3 IDLE
        step();                                      // c4 SEARCH
        chk("rr_c4_valid", 32'(result_valid), 32'd0);
        step();                                      // c5 REPORT
        chk("rr_p3_valid", 32'(result_valid), 32'd1);
        chk("rr_p3_player", 32'(result_player), 32'd3);
        chk("rr_p3_result", 32'(result), 32'd3);
        step();                                      // c6 IDLE
        step();                                      // c7 SEARCH
        step();                                      // c8 REPORT
        chk("rr_p0_valid", 32'(result_valid), 32'd1);
        chk("rr_p0_player", 32'(result_player), 32'd0);
        chk("rr_p0_result", 32'(result), 32'd2);
        chk("rr_done", 32'(player_done_), 32'b1011);
        press_ = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
